// File: rtl/palindrome_scan_sched_if.sv
// Bundles the requester-side and result-side handshakes of the shared
// palindrome window detector. Clock and reset stay outside the bundle.
interface palindrome_scan_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WORD_W  = 8
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned HIT_W = $clog2(WORD_W - 1);

   // requester side
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*WORD_W-1:0] req_word_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      flush_i;

   // result side
   logic                      res_valid_o;
   logic                      res_ready_i;
   logic [ID_W-1:0]           res_id_o;
   logic [WORD_W-3:0]         res_mask_o;
   logic [HIT_W-1:0]          res_hits_o;
   logic                      busy_o;

   // producers/consumer drive the inputs
   modport master (
      output req_valid_i, req_word_i, flush_i, res_ready_i,
      input  req_ready_o, res_valid_o, res_id_o, res_mask_o, res_hits_o, busy_o
   );

   // the scheduler
   modport slave (
      input  req_valid_i, req_word_i, flush_i, res_ready_i,
      output req_ready_o, res_valid_o, res_id_o, res_mask_o, res_hits_o, busy_o
   );
endinterface

// File: rtl/palindrome_scan_sched.sv
// Shares one serial 3-bit palindrome window detector between NUM_REQ
// requesters. A round-robin arbiter accepts one word, the word is shifted
// MSB-first through the window one bit per cycle, and a hit mask plus hit
// count is returned tagged with the owning requester ID.
module palindrome_scan_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WORD_W  = 8
) (
   input logic                    clk,
   input logic                    reset,
   palindrome_scan_sched_if.slave bus
);
   localparam int unsigned ID_W   = $clog2(NUM_REQ);
   localparam int unsigned HIT_W  = $clog2(WORD_W - 1);
   localparam int unsigned K_W    = $clog2(WORD_W);
   localparam int unsigned MASK_W = WORD_W - 2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] word_q,  word_d;
   logic [ID_W-1:0]   id_q,    id_d;
   logic [ID_W-1:0]   rr_q,    rr_d;
   logic [K_W-1:0]    k_q,     k_d;
   logic [1:0]        win_q,   win_d;
   logic [MASK_W-1:0] mask_q,  mask_d;
   logic [HIT_W-1:0]  hits_q,  hits_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [WORD_W-1:0] gnt_word;
   logic              cur_bit;
   logic              cmp_en;
   logic              match;
   logic              accept;

   // Round-robin search: first valid requester after the rr pointer, wrapping.
   always_comb begin
      logic [ID_W-1:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((32'(rr_q) + i) % NUM_REQ);
         if (!gnt_found && bus.req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Select the granted requester's word from the flat word bus.
   always_comb begin
      gnt_word = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (ID_W'(r) == gnt_idx) begin
            gnt_word = bus.req_word_i[r*WORD_W +: WORD_W];
         end
      end
   end

   // A grant is taken only in IDLE, never during flush or while reset is held.
   assign accept = (state_q == S_IDLE) && gnt_found && !bus.flush_i && !reset;

   // One-hot accept strobe for the granted requester.
   always_comb begin
      bus.req_ready_o = '0;
      if (accept) begin
         bus.req_ready_o[gnt_idx] = 1'b1;
      end
   end

   // The newest window position is the incoming bit itself, so only the two
   // older positions are stored: win_q[0] = word[k+1], win_q[1] = word[k+2].
   assign cur_bit = word_q[k_q];
   assign cmp_en  = 32'(k_q) < MASK_W;
   assign match   = (win_q[1] == cur_bit);

   // Next-state logic for the IDLE / SHIFT / REPORT controller.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      id_d    = id_q;
      rr_d    = rr_q;
      k_d     = k_q;
      win_d   = win_q;
      mask_d  = mask_q;
      hits_d  = hits_q;

      if (bus.flush_i) begin
         // Abort: in-flight word and partial result are discarded, rr kept.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  word_d  = gnt_word;
                  id_d    = gnt_idx;
                  rr_d    = gnt_idx;
                  k_d     = K_W'(WORD_W - 1);
                  win_d   = '0;
                  mask_d  = '0;
                  hits_d  = '0;
                  state_d = S_SHIFT;
               end
            end
            S_SHIFT: begin
               win_d = {win_q[0], cur_bit};
               if (cmp_en) begin
                  for (int unsigned j = 0; j < MASK_W; j++) begin
                     if (K_W'(j) == k_q) begin
                        mask_d[j] = match;
                     end
                  end
                  if (match) begin
                     hits_d = hits_q + HIT_W'(1);
                  end
               end
               if (k_q == '0) begin
                  state_d = S_REPORT;
               end else begin
                  k_d = k_q - K_W'(1);
               end
            end
            S_REPORT: begin
               if (bus.res_ready_i) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         id_q    <= '0;
         rr_q    <= ID_W'(NUM_REQ - 1);
         k_q     <= '0;
         win_q   <= '0;
         mask_q  <= '0;
         hits_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         k_q     <= k_d;
         win_q   <= win_d;
         mask_q  <= mask_d;
         hits_q  <= hits_d;
      end
   end

   assign bus.res_valid_o = (state_q == S_REPORT);
   assign bus.res_id_o    = id_q;
   assign bus.res_mask_o  = mask_q;
   assign bus.res_hits_o  = hits_q;
   assign bus.busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_palindrome_scan_sched.sv
// Self-checking bench for palindrome_scan_sched: directed scenarios plus
// randomized jobs checked against a word-level reference model.
module tb_palindrome_scan_sched;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WORD_W  = 8;
   localparam int unsigned MW      = WORD_W - 2;

   logic clk;
   logic reset;
   int   total;
   int   passed;
   int   rr_m;
   logic [WORD_W-1:0] words [NUM_REQ];

   palindrome_scan_sched_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

   palindrome_scan_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: mask bit j set iff word[j+2] == word[j].
   function automatic logic [MW-1:0] ref_mask(input logic [WORD_W-1:0] w);
      logic [MW-1:0] m;
      for (int j = 0; j < int'(MW); j++) m[j] = (w[j+2] == w[j]);
      return m;
   endfunction

   function automatic int ref_hits(input logic [WORD_W-1:0] w);
      int c;
      logic [MW-1:0] m;
      m = ref_mask(w);
      c = 0;
      for (int j = 0; j < int'(MW); j++) c += int'(m[j]);
      return c;
   endfunction

   // Reference arbiter: first valid index after rr, wrapping; -1 when none.
   function automatic int ref_grant(input logic [NUM_REQ-1:0] v, input int rr);
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         if (v[(rr + i) % NUM_REQ]) return (rr + i) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_words();
      for (int r = 0; r < int'(NUM_REQ); r++) bus.req_word_i[r*WORD_W +: WORD_W] = words[r];
   endtask

   // Waits (bounded) for res_valid_o; n counts posedges waited.
   task automatic wait_result(input bit rand_ready, output int n);
      n = 0;
      do begin
         if (rand_ready) bus.res_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!bus.res_valid_o && n < 40);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid_i = '0;
      bus.req_word_i  = '0;
      bus.flush_i     = 1'b0;
      bus.res_ready_i = 1'b0;
      tick();
      total++; if (bus.res_valid_o !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", bus.res_valid_o); else passed++;
      total++; if (bus.req_ready_o !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", bus.req_ready_o); else passed++;
      total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy_o); else passed++;
      total++; if ({bus.res_id_o, bus.res_mask_o, bus.res_hits_o} !== '0)
         $display("FAIL reset_res_fields got %h/%h/%h want 0", bus.res_id_o, bus.res_mask_o, bus.res_hits_o); else passed++;
      reset = 1'b0;
      rr_m = NUM_REQ - 1;
      tick();
   endtask

   task automatic test_single();
      int n;
      words[0] = 8'hAA;
      load_words();
      bus.req_valid_i = 4'b0001;
      bus.res_ready_i = 1'b1;
      #1;
      total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL single_grant got %b want 0001", bus.req_ready_o); else passed++;
      tick();
      rr_m = 0;
      bus.req_valid_i = '0;
      total++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy got %0b want 1", bus.busy_o); else passed++;
      wait_result(1'b0, n);
      total++; if (n != int'(WORD_W)) $display("FAIL single_latency got %0d want %0d", n, WORD_W); else passed++;
      total++; if (bus.res_id_o !== 2'd0) $display("FAIL single_id got %0d want 0", bus.res_id_o); else passed++;
      total++; if (bus.res_mask_o !== 6'b111111) $display("FAIL single_mask got %b want 111111", bus.res_mask_o); else passed++;
      total++; if (bus.res_hits_o !== 3'd6) $display("FAIL single_hits_max got %0d want 6", bus.res_hits_o); else passed++;
      tick();
      total++; if (bus.res_valid_o !== 1'b0) $display("FAIL single_valid_drop got %0b want 0", bus.res_valid_o); else passed++;
   endtask

   task automatic test_patterns();
      int n;
      int r;
      logic [WORD_W-1:0] w;
      logic [WORD_W-1:0] fixed_words [2];
      fixed_words[0] = 8'b1100_1100;
      fixed_words[1] = 8'h10;
      for (int t = 0; t < 8; t++) begin
         r = (t < 2) ? 1 : int'($urandom_range(0, NUM_REQ - 1));
         w = (t < 2) ? fixed_words[t] : WORD_W'($urandom);
         words[r] = w;
         load_words();
         bus.req_valid_i = '0;
         bus.req_valid_i[r] = 1'b1;
         #1;
         total++; if (bus.req_ready_o !== 4'(1 << r)) $display("FAIL pat_grant got %b want %b", bus.req_ready_o, 4'(1 << r)); else passed++;
         tick();
         rr_m = r;
         bus.req_valid_i = '0;
         wait_result(1'b0, n);
         total++; if (!bus.res_valid_o) $display("FAIL pat_timeout got no result want result within 40 cycles"); else passed++;
         total++; if (bus.res_id_o !== 2'(r)) $display("FAIL pat_id got %0d want %0d", bus.res_id_o, r); else passed++;
         total++; if (bus.res_mask_o !== ref_mask(w)) $display("FAIL pat_mask word %h got %b want %b", w, bus.res_mask_o, ref_mask(w)); else passed++;
         total++; if (int'(bus.res_hits_o) != ref_hits(w)) $display("FAIL pat_hits word %h got %0d want %0d", w, bus.res_hits_o, ref_hits(w)); else passed++;
         tick();
      end
   endtask

   task automatic test_round_robin();
      int n;
      int exp;
      int order [5];
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rr_m = NUM_REQ - 1;
      for (int r = 0; r < int'(NUM_REQ); r++) words[r] = WORD_W'($urandom);
      load_words();
      bus.req_valid_i = 4'b1111;
      bus.res_ready_i = 1'b1;
      for (int j = 0; j < 5; j++) begin
         n = 0;
         #1;
         while (bus.req_ready_o == '0 && n < 20) begin tick(); n++; end
         exp = ref_grant(4'b1111, rr_m);
         order[j] = exp;
         total++; if (bus.req_ready_o !== 4'(1 << exp)) $display("FAIL rr_grant job %0d got %b want %b", j, bus.req_ready_o, 4'(1 << exp)); else passed++;
         tick();
         rr_m = exp;
         total++; if (bus.req_ready_o !== 4'b0) $display("FAIL rr_pulse job %0d got %b want 0000", j, bus.req_ready_o); else passed++;
         wait_result(1'b0, n);
         total++; if (bus.res_id_o !== 2'(exp) || !bus.res_valid_o) $display("FAIL rr_id job %0d got %0d want %0d", j, bus.res_id_o, exp); else passed++;
         total++; if (bus.res_mask_o !== ref_mask(words[exp])) $display("FAIL rr_mask job %0d got %b want %b", j, bus.res_mask_o, ref_mask(words[exp])); else passed++;
         tick();
      end
      total++; if (order[4] != 0 || order[3] != 3 || order[0] != 0) $display("FAIL rr_order got %0d,%0d,%0d want 0,3,0", order[0], order[3], order[4]); else passed++;
      bus.req_valid_i = '0;
      tick();
   endtask

   task automatic test_backpressure();
      int n;
      int exp;
      logic [1:0]    id0;
      logic [MW-1:0] m0;
      logic [2:0]    h0;
      words[2] = WORD_W'($urandom);
      load_words();
      bus.req_valid_i = 4'b0100;
      bus.res_ready_i = 1'b0;
      tick();
      rr_m = 2;
      bus.req_valid_i = 4'b1001;
      wait_result(1'b0, n);
      id0 = bus.res_id_o; m0 = bus.res_mask_o; h0 = bus.res_hits_o;
      total++; if (m0 !== ref_mask(words[2])) $display("FAIL bp_mask got %b want %b", m0, ref_mask(words[2])); else passed++;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if (!bus.res_valid_o || bus.res_id_o !== 2'd2 || bus.res_mask_o !== m0 || bus.res_hits_o !== h0)
            $display("FAIL bp_hold cycle %0d got v%0b id%0d m%b h%0d want v1 id2 m%b h%0d",
                     c, bus.res_valid_o, bus.res_id_o, bus.res_mask_o, bus.res_hits_o, m0, h0); else passed++;
         total++; if (bus.req_ready_o !== 4'b0) $display("FAIL bp_ready cycle %0d got %b want 0000", c, bus.req_ready_o); else passed++;
      end
      bus.res_ready_i = 1'b1;
      tick();
      exp = ref_grant(4'b1001, rr_m);
      total++; if (bus.res_valid_o !== 1'b0) $display("FAIL bp_valid_drop got %0b want 0", bus.res_valid_o); else passed++;
      total++; if (bus.req_ready_o !== 4'(1 << exp)) $display("FAIL bp_resume got %b want %b", bus.req_ready_o, 4'(1 << exp)); else passed++;
      bus.req_valid_i = '0;
      tick();
      total++; if (bus.busy_o !== 1'b0) $display("FAIL bp_drop_no_grant got busy %0b want 0", bus.busy_o); else passed++;
   endtask

   task automatic test_flush();
      int seen;
      int exp;
      words[1] = WORD_W'($urandom);
      load_words();
      bus.req_valid_i = 4'b0010;
      bus.res_ready_i = 1'b1;
      tick();
      rr_m = 1;
      bus.req_valid_i = '0;
      tick(); tick(); tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      total++; if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) $display("FAIL flush_idle got busy %0b valid %0b want 0 0", bus.busy_o, bus.res_valid_o); else passed++;
      seen = 0;
      for (int c = 0; c < 12; c++) begin tick(); if (bus.res_valid_o) seen++; end
      total++; if (seen != 0) $display("FAIL flush_no_result got %0d valid cycles want 0", seen); else passed++;
      bus.req_valid_i = 4'b1111;
      bus.flush_i = 1'b1;
      #1;
      total++; if (bus.req_ready_o !== 4'b0) $display("FAIL flush_blocks_grant got %b want 0000", bus.req_ready_o); else passed++;
      tick();
      bus.flush_i = 1'b0;
      #1;
      exp = ref_grant(4'b1111, rr_m);
      total++; if (bus.req_ready_o !== 4'(1 << exp)) $display("FAIL flush_rr_kept got %b want %b", bus.req_ready_o, 4'(1 << exp)); else passed++;
      bus.req_valid_i = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      int n;
      words[3] = WORD_W'($urandom);
      words[1] = WORD_W'($urandom);
      load_words();
      bus.req_valid_i = 4'b1000;
      tick();
      bus.req_valid_i = 4'b0110;
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      total++; if ({bus.res_valid_o, bus.busy_o, bus.req_ready_o, bus.res_id_o, bus.res_mask_o, bus.res_hits_o} !== '0)
         $display("FAIL midreset_outputs got v%0b b%0b r%b id%0d m%b h%0d want all 0",
                  bus.res_valid_o, bus.busy_o, bus.req_ready_o, bus.res_id_o, bus.res_mask_o, bus.res_hits_o); else passed++;
      @(negedge clk);
      reset = 1'b0;
      rr_m = NUM_REQ - 1;
      #1;
      total++; if (bus.req_ready_o !== 4'b0010) $display("FAIL midreset_first_grant got %b want 0010", bus.req_ready_o); else passed++;
      tick();
      rr_m = 1;
      bus.req_valid_i = '0;
      bus.res_ready_i = 1'b1;
      wait_result(1'b0, n);
      total++; if (bus.res_id_o !== 2'd1 || bus.res_mask_o !== ref_mask(words[1]))
         $display("FAIL midreset_job got id%0d m%b want id1 m%b", bus.res_id_o, bus.res_mask_o, ref_mask(words[1])); else passed++;
      tick();
   endtask

   task automatic test_random();
      int n;
      int exp;
      int stall;
      logic [NUM_REQ-1:0] v;
      for (int t = 0; t < 25; t++) begin
         for (int r = 0; r < int'(NUM_REQ); r++) words[r] = WORD_W'($urandom);
         load_words();
         v = NUM_REQ'($urandom_range(1, 15));
         bus.req_valid_i = v;
         #1;
         exp = ref_grant(v, rr_m);
         total++; if (bus.req_ready_o !== 4'(1 << exp)) $display("FAIL rand_grant v %b got %b want %b", v, bus.req_ready_o, 4'(1 << exp)); else passed++;
         tick();
         rr_m = exp;
         bus.req_valid_i = '0;
         wait_result(1'b1, n);
         total++; if (n != int'(WORD_W) || !bus.res_valid_o) $display("FAIL rand_latency got %0d want %0d", n, WORD_W); else passed++;
         total++; if (bus.res_id_o !== 2'(exp) || bus.res_mask_o !== ref_mask(words[exp]) || int'(bus.res_hits_o) != ref_hits(words[exp]))
            $display("FAIL rand_result got id%0d m%b h%0d want id%0d m%b h%0d", bus.res_id_o, bus.res_mask_o, bus.res_hits_o,
                     exp, ref_mask(words[exp]), ref_hits(words[exp])); else passed++;
         stall = $urandom_range(0, 3);
         bus.res_ready_i = 1'b0;
         for (int c = 0; c < stall; c++) begin
            tick();
            total++; if (!bus.res_valid_o || bus.res_mask_o !== ref_mask(words[exp]))
               $display("FAIL rand_hold got v%0b m%b want v1 m%b", bus.res_valid_o, bus.res_mask_o, ref_mask(words[exp])); else passed++;
         end
         bus.res_ready_i = 1'b1;
         tick();
         total++; if (bus.res_valid_o !== 1'b0) $display("FAIL rand_valid_drop got %0b want 0", bus.res_valid_o); else passed++;
      end
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rr_m   = NUM_REQ - 1;
      for (int r = 0; r < int'(NUM_REQ); r++) words[r] = '0;
      test_reset();
      test_single();
      test_patterns();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
